// File: rtl/branch_resolve_pipe.sv
// RV32I branch condition resolver behind a 1- or 2-stage valid/ready pipeline.
// Define BRANCH_STATS_EN to compile in the saturating total/taken statistics counters.
module branch_resolve_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             br_taken,
  output logic             br_eq,
  output logic             br_lt,
  output logic             illegal,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef struct packed {
    logic taken;
    logic eq;
    logic lt;
    logic illegal;
  } res_t;

  function automatic res_t resolve(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    res_t r;
    logic signed_cmp;
    signed_cmp = (f3 == 3'b100) || (f3 == 3'b101);
    r.eq       = (a == b);
    r.lt       = signed_cmp ? ($signed(a) < $signed(b)) : (a < b);
    r.taken    = 1'b0;
    r.illegal  = 1'b0;
    case (f3)
      3'b000:          r.taken = r.eq;
      3'b001:          r.taken = !r.eq;
      3'b100, 3'b110:  r.taken = r.lt;
      3'b101, 3'b111:  r.taken = !r.lt;
      default:         r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  res_t            r_res;
  logic            r_out_valid;
  logic            w_out_free;
  logic            w_stage1_free;
  logic            w_src_valid;
  logic [2:0]      w_src_f3;
  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_src_b;

  assign w_out_free = !r_out_valid || out_ready;

  generate
    if (STAGES == 2) begin : g_two_stage
      logic            r_s1_valid;
      logic [2:0]      r_s1_f3;
      logic [XLEN-1:0] r_s1_a;
      logic [XLEN-1:0] r_s1_b;

      // Stage 1 can take a new request when empty or when it hands off to the result stage.
      assign w_stage1_free = !r_s1_valid || w_out_free;

      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s1_valid <= 1'b0;
          r_s1_f3    <= '0;
          r_s1_a     <= '0;
          r_s1_b     <= '0;
        end else if (flush) begin
          r_s1_valid <= 1'b0;
        end else if (w_stage1_free) begin
          r_s1_valid <= in_valid;
          if (in_valid) begin
            r_s1_f3 <= funct3;
            r_s1_a  <= rs1;
            r_s1_b  <= rs2;
          end
        end
      end

      assign w_src_valid = r_s1_valid;
      assign w_src_f3    = r_s1_f3;
      assign w_src_a     = r_s1_a;
      assign w_src_b     = r_s1_b;
    end else begin : g_one_stage
      assign w_stage1_free = w_out_free;
      assign w_src_valid   = in_valid;
      assign w_src_f3      = funct3;
      assign w_src_a       = rs1;
      assign w_src_b       = rs2;
    end
  endgenerate

  assign in_ready = rst_n && !flush && w_stage1_free;

  always_ff @(posedge clk) begin
    // NOTE: data registers are reset along with the valid bits so no stale result survives a reset.
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_out_free) begin
      r_out_valid <= w_src_valid;
      if (w_src_valid) r_res <= resolve(w_src_f3, w_src_a, w_src_b);
    end
  end

  assign out_valid = r_out_valid;
  assign br_taken  = r_out_valid && r_res.taken;
  assign br_eq     = r_out_valid && r_res.eq;
  assign br_lt     = r_out_valid && r_res.lt;
  assign illegal   = r_out_valid && r_res.illegal;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_total_cnt;
  logic [CNT_W-1:0] r_taken_cnt;
  logic             w_count;

  // A flushed handshake is not a delivery, so it is never counted.
  assign w_count = r_out_valid && out_ready && !flush && !r_res.illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_total_cnt <= '0;
      r_taken_cnt <= '0;
    end else if (w_count) begin
      if (r_total_cnt != '1) r_total_cnt <= r_total_cnt + 1'b1;
      if (r_res.taken && (r_taken_cnt != '1)) r_taken_cnt <= r_taken_cnt + 1'b1;
    end
  end

  assign total_cnt = r_total_cnt;
  assign taken_cnt = r_taken_cnt;
`else
  assign total_cnt = '0;
  assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Scoreboard bench: lane 0 drives a STAGES=1 instance, lane 1 a STAGES=2/CNT_W=4 instance.
// Expected results come from an arithmetic reference model of the branch rules.
module tb_branch_resolve_pipe;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  typedef struct {
    logic taken;
    logic eq;
    logic lt;
    logic ill;
    int   acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [2:0]  funct3    [2];
  logic [31:0] rs1       [2];
  logic [31:0] rs2       [2];
  logic        flush     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        br_taken  [2];
  logic        br_eq     [2];
  logic        br_lt     [2];
  logic        illegal   [2];
  logic [15:0] total0, taken0;
  logic [3:0]  total1, taken1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_pipe #(.XLEN(32), .STAGES(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .funct3(funct3[0]), .rs1(rs1[0]), .rs2(rs2[0]), .flush(flush[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .br_taken(br_taken[0]),
    .br_eq(br_eq[0]), .br_lt(br_lt[0]), .illegal(illegal[0]),
    .total_cnt(total0), .taken_cnt(taken0)
  );

  branch_resolve_pipe #(.XLEN(32), .STAGES(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .funct3(funct3[1]), .rs1(rs1[1]), .rs2(rs2[1]), .flush(flush[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .br_taken(br_taken[1]),
    .br_eq(br_eq[1]), .br_lt(br_lt[1]), .illegal(illegal[1]),
    .total_cnt(total1), .taken_cnt(taken1)
  );

  task automatic check(input string name, input int lane, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h", lane, name, got, exp);
    end
  endtask

  // Reference model: operands as mathematical integers, branch rules by mnemonic.
  function automatic exp_t ref_model(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    exp_t        e;
    longint      ua, ub, sa, sb;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = (ua >= 64'd2147483648) ? ua - 64'd4294967296 : ua;
    sb = (ub >= 64'd2147483648) ? ub - 64'd4294967296 : ub;
    e.eq  = (ua == ub);
    e.lt  = (f3 == 3'd4 || f3 == 3'd5) ? (sa < sb) : (ua < ub);
    e.ill = (f3 == 3'd2 || f3 == 3'd3);
    case (f3)
      3'd0:    e.taken = e.eq;
      3'd1:    e.taken = !e.eq;
      3'd4:    e.taken = e.lt;
      3'd5:    e.taken = !e.lt;
      3'd6:    e.taken = e.lt;
      3'd7:    e.taken = !e.lt;
      default: e.taken = 1'b0;
    endcase
    e.acc = 0;
    return e;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_mon
    localparam int ST   = (k == 0) ? 1 : 2;
    localparam int CMAX = (k == 0) ? 65535 : 15;
    logic [15:0] tot_w, tak_w;
    if (k == 0) begin : g_c0
      assign tot_w = total0;
      assign tak_w = taken0;
    end else begin : g_c1
      assign tot_w = {12'd0, total1};
      assign tak_w = {12'd0, taken1};
    end

    exp_t       q[$];
    exp_t       e;
    int         cyc = 0;
    int         last_stall = -1000;
    int         m_total = 0;
    int         m_taken = 0;
    bit         prev_rst_low = 1'b0;
    bit         prev_flush = 1'b0;
    bit         prev_hold = 1'b0;
    logic [3:0] held = '0;
    logic [3:0] outs;

    always @(negedge clk) begin
      cyc++;
      outs = {br_taken[k], br_eq[k], br_lt[k], illegal[k]};
      if (!rst_n[k]) begin
        check("in_ready_in_reset", k, 64'(in_ready[k]), 64'd0);
        if (prev_rst_low) begin
          check("out_valid_in_reset", k, 64'(out_valid[k]), 64'd0);
          check("total_cnt_in_reset", k, 64'(tot_w), 64'd0);
          check("taken_cnt_in_reset", k, 64'(tak_w), 64'd0);
        end
        q.delete();
        m_total   = 0;
        m_taken   = 0;
        prev_hold = 1'b0;
      end else begin
        if (prev_rst_low && !flush[k]) check("ready_after_reset", k, 64'(in_ready[k]), 64'd1);
        if (prev_flush) check("out_valid_after_flush", k, 64'(out_valid[k]), 64'd0);
        if (!out_valid[k]) check("idle_outputs_zero", k, 64'(outs), 64'd0);
        if (prev_hold) begin
          check("stall_valid_held", k, 64'(out_valid[k]), 64'd1);
          check("stall_outputs_stable", k, 64'(outs), 64'(held));
        end
        check("total_cnt", k, 64'(tot_w), 64'(m_total));
        check("taken_cnt", k, 64'(tak_w), 64'(m_taken));
        if (flush[k]) begin
          check("in_ready_during_flush", k, 64'(in_ready[k]), 64'd0);
          q.delete();
        end else begin
          if (out_valid[k] && out_ready[k]) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL lane%0d unexpected_output: got a result, expected none", k);
            end else begin
              e = q.pop_front();
              check("br_taken", k, 64'(br_taken[k]), 64'(e.taken));
              check("br_eq", k, 64'(br_eq[k]), 64'(e.eq));
              check("br_lt", k, 64'(br_lt[k]), 64'(e.lt));
              check("illegal", k, 64'(illegal[k]), 64'(e.ill));
              if (last_stall < e.acc) check("latency", k, 64'(cyc - e.acc), 64'(ST));
              if (STATS && !e.ill) begin
                if (m_total < CMAX) m_total++;
                if (e.taken && m_taken < CMAX) m_taken++;
              end
            end
          end
          if (in_valid[k] && in_ready[k]) begin
            e     = ref_model(funct3[k], rs1[k], rs2[k]);
            e.acc = cyc;
            q.push_back(e);
          end
        end
        if (!out_ready[k]) last_stall = cyc;
        prev_hold = !flush[k] && out_valid[k] && !out_ready[k];
        held      = outs;
      end
      prev_rst_low = !rst_n[k];
      prev_flush   = flush[k] && rst_n[k];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input req_t r);
    funct3[k] = r.f3;
    rs1[k]    = r.a;
    rs2[k]    = r.b;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 4))
      0:       r.a = 32'h8000_0000;
      1:       r.a = 32'h7fff_ffff;
      2:       r.a = 32'h0000_0000;
      3:       r.a = 32'hffff_ffff;
      default: r.a = $urandom;
    endcase
    case ($urandom_range(0, 3))
      0:       r.b = r.a;
      1:       r.b = r.a + 32'd1;
      2:       r.b = r.a - 32'd1;
      default: r.b = $urandom;
    endcase
    return r;
  endfunction

  task automatic do_reset(input int k, input int n);
    rst_n[k]     = 1'b0;
    in_valid[k]  = 1'b0;
    flush[k]     = 1'b0;
    out_ready[k] = 1'b1;
    repeat (n) step();
    rst_n[k] = 1'b1;
  endtask

  // Offers each request until accepted; out_ready is low for cycles lo..hi of the run.
  task automatic run_reqs(input int k, input req_t reqs[$], input int lo, input int hi,
                          output bit saw_low);
    int idx = 0;
    int c   = 0;
    saw_low = 1'b0;
    while (idx < reqs.size() && c < 200) begin
      out_ready[k] = !(c >= lo && c <= hi);
      in_valid[k]  = 1'b1;
      set_req(k, reqs[idx]);
      @(negedge clk);
      if (in_ready[k]) idx++;
      else saw_low = 1'b1;
      step();
      c++;
    end
    check("requests_accepted", k, 64'(idx), 64'(reqs.size()));
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    repeat (6) step();
  endtask

  task automatic lane_seq(input int k);
    req_t r;
    req_t dir[$];
    req_t four[$];
    req_t beq[$];
    bit   low;

    do_reset(k, 3);
    step();

    dir.push_back('{3'b110, 32'h8000_0000, 32'h8000_0000});
    dir.push_back('{3'b110, 32'h8000_0000, 32'h8000_0001});
    dir.push_back('{3'b100, 32'h8000_0001, 32'h8000_0000});
    dir.push_back('{3'b101, 32'h8000_0000, 32'h0000_0001});
    dir.push_back('{3'b011, 32'h0000_0005, 32'h0000_0005});
    dir.push_back('{3'b010, 32'hffff_ffff, 32'h0000_0001});
    dir.push_back('{3'b001, 32'h1234_5678, 32'h1234_5678});
    dir.push_back('{3'b111, 32'h0000_0001, 32'hffff_ffff});
    run_reqs(k, dir, -1, -1, low);

    for (int i = 0; i < 4; i++) four.push_back(rand_req());
    run_reqs(k, four, 3, 5, low);
    check("ready_low_when_full", k, 64'(low), 64'd1);

    out_ready[k] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[k] = 1'b1;
      set_req(k, rand_req());
      step();
    end
    flush[k]    = 1'b1;
    in_valid[k] = 1'b1;
    set_req(k, '{3'b000, 32'd7, 32'd7});
    step();
    flush[k]     = 1'b0;
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    step();
    dir.delete();
    dir.push_back('{3'b100, 32'hffff_fffe, 32'h0000_0003});
    run_reqs(k, dir, -1, -1, low);

    for (int i = 0; i < 20; i++) begin
      r.f3 = 3'b000;
      r.a  = $urandom;
      r.b  = r.a;
      beq.push_back(r);
    end
    run_reqs(k, beq, -1, -1, low);
    if (k == 1) begin
      check("sat_total_cnt", k, 64'(total1), STATS ? 64'hf : 64'h0);
      check("sat_taken_cnt", k, 64'(taken1), STATS ? 64'hf : 64'h0);
    end

    out_ready[k] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[k] = 1'b1;
      set_req(k, rand_req());
      step();
    end
    do_reset(k, 2);
    if (k == 1) begin
      check("total_cnt_after_reset", k, 64'(total1), 64'd0);
      check("taken_cnt_after_reset", k, 64'(taken1), 64'd0);
    end
    run_reqs(k, dir, -1, -1, low);

    repeat (400) begin
      in_valid[k]  = ($urandom_range(0, 3) != 0);
      out_ready[k] = ($urandom_range(0, 9) < 7);
      flush[k]     = ($urandom_range(0, 29) == 0);
      set_req(k, rand_req());
      step();
    end
    flush[k]     = 1'b0;
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k]     = 1'b0;
      in_valid[k]  = 1'b0;
      funct3[k]    = '0;
      rs1[k]       = '0;
      rs2[k]       = '0;
      flush[k]     = 1'b0;
      out_ready[k] = 1'b1;
    end
    fork
      lane_seq(0);
      lane_seq(1);
    join
    check("scoreboard_drained", 0, 64'(g_mon[0].q.size()), 64'd0);
    check("scoreboard_drained", 1, 64'(g_mon[1].q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/branch_resolve_pipe.md
BRANCH_RESOLVE_PIPE -- requirements
Module: branch_resolve_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 32, operand width in bits (legal values 8..64).
REQ-002 SHALL provide parameter STAGES, default 1, pipeline depth (legal values 1 or 2).
REQ-003 SHALL provide parameter CNT_W, default 16, width of the statistics counters.
REQ-004 SHALL have one clock and a synchronous, active-low reset; ports listed clock and reset first:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- funct3  in  3  RV32I branch funct3 encoding
- rs1  in  XLEN  first operand
- rs2  in  XLEN  second operand
- flush  in  1  drop all in-flight requests
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- br_taken  out  1  branch condition true
- br_eq  out  1  rs1 == rs2
- br_lt  out  1  rs1 < rs2, signed or unsigned per funct3
- illegal  out  1  funct3 is 010 or 011
- total_cnt  out  CNT_W  resolved legal branches
- taken_cnt  out  CNT_W  resolved taken branches

Function
REQ-005 SHALL accept a request when in_valid && in_ready at a clock edge.
REQ-006 SHALL decode funct3: 000 BEQ taken=eq; 001 BNE taken=!eq; 100 BLT signed lt; 101 BGE signed !lt; 110 BLTU unsigned lt; 111 BGEU unsigned !lt.
REQ-007 SHALL, for funct3 010/011, set illegal=1, br_taken=0; br_eq/br_lt still reported, unsigned compare.
REQ-008 SHALL compute br_lt signed for 100/101, unsigned for all other encodings.
REQ-009 SHALL, with out_ready held 1, present out_valid exactly STAGES cycles after acceptance.
REQ-010 STAGES=1: one result register; STAGES=2: stage 1 registers funct3/operands, stage 2 registers result.
REQ-011 SHALL hold all result outputs stable while out_valid && !out_ready.
REQ-012 SHALL set in_ready = !flush && (stage 1 empty || stage 1 advances this cycle); full throughput of one request per cycle under out_ready=1.
REQ-013 SHALL never drop, duplicate or reorder requests.
REQ-014 flush=1 SHALL clear every stage valid bit at that edge; the request offered that cycle is not accepted; out_valid=0 next cycle.
REQ-015 flush SHALL take priority over a simultaneous output handshake; that result is neither counted nor considered delivered.
REQ-016 SHALL drive br_taken, br_eq, br_lt, illegal to 0 whenever out_valid=0.

Reset
REQ-017 rst_n=0 at a clock edge SHALL clear all valid bits, data registers and counters; out_valid=0, in_ready=0 during reset.
REQ-018 Reset asserted mid-operation SHALL discard in-flight requests; in_ready=1 the first cycle after rst_n returns 1.

Configuration
REQ-019 Macro BRANCH_STATS_EN SHALL compile in counters: on each output handshake with illegal=0, total_cnt +1; taken_cnt +1 if also br_taken=1.
REQ-020 Counters SHALL saturate at all-ones, never wrap.
REQ-021 Without BRANCH_STATS_EN, total_cnt and taken_cnt SHALL be constant 0 and no counter flops are synthesised.

Verification
REQ-022 XLEN=32, STAGES=1: funct3=110, rs1=rs2=0x80000000 -> 1 cycle later br_eq=1, br_lt=0, br_taken=0.
REQ-023 funct3=110, rs1=0x80000000, rs2=0x80000001 -> br_lt=1, br_taken=1; funct3=100, rs1=0x80000001, rs2=0x80000000 -> br_lt=0; funct3=101, rs1=0x80000000, rs2=0x00000001 -> br_lt=1, br_taken=0.
REQ-024 STAGES=2: 4 back-to-back requests, out_ready low cycles 3-5 -> results in order, outputs stable while stalled, in_ready low once both stages are full.
REQ-025 Flush with 2 in flight plus one offered -> out_valid=0 next cycle, nothing counted, next request resolves normally.
REQ-026 funct3=011 -> illegal=1, br_taken=0, total_cnt unchanged.
REQ-027 BRANCH_STATS_EN, CNT_W=4: 20 taken BEQ handshakes -> total_cnt=taken_cnt=0xF; then reset -> both 0.
